// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// The ovf signal exists only when CHUNKED_ADDER_OVF_EN is defined.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
`ifdef CHUNKED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum
`ifdef CHUNKED_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum
`ifdef CHUNKED_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first.
// Define CHUNKED_ADDER_OVF_EN to add the signed-overflow output bus.ovf.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic            clk,
    input logic            rst,
    chunked_adder_if.slave bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH:0]   r_sum;
    logic [CHUNK:0]   w_slice;
    logic             w_last;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_out_valid;

    // Operands shift right each cycle so the active slice is always the low CHUNK bits
    assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};
    assign w_last  = (r_idx == IDXW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_ADD;
                end
            end
            S_ADD: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1; cin is ignored in that mode
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_ADD) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_slice[CHUNK];
            r_idx   <= r_idx + 1'b1;
            r_sum[r_idx*CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
            if (w_last) begin
                r_sum[WIDTH] <= w_slice[CHUNK];
            end
        end
    end

`ifdef CHUNKED_ADDER_OVF_EN
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    // Sign bits captured at accept; r_bmsb is that of the effective (possibly inverted) b
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_amsb <= bus.a[WIDTH-1];
            r_bmsb <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            r_ovf  <= 1'b0;
        end else if ((r_state == S_ADD) && w_last) begin
            r_ovf  <= (r_amsb == r_bmsb) && (w_slice[CHUNK-1] != r_amsb);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed plus short random checks of chunked_adder (WIDTH=16, CHUNK=4) using a result scoreboard.
// Build with CHUNKED_ADDER_OVF_EN defined to also check ovf.
module tb_chunked_adder;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH:0] sum;
        logic           ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chunked_adder_if #(.WIDTH(WIDTH)) bus ();

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        if (sub) begin
            e.sum = {1'b0, a} - {1'b0, b} + 17'h10000;
            e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            e.sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        end
        return e;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first ADD cycle
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic [WIDTH:0] esum,
                        input logic eovf, input bit push);
        exp_t e;
        chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        e.sum = esum;
        e.ovf = eovf;
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Latency counted in cycles from the accept cycle to the first out_valid cycle
    task automatic collect(input string tag);
        exp_t e;
        int   lat;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(bus.sum), 32'(e.sum));
`ifdef CHUNKED_ADDER_OVF_EN
            chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
`endif
        end
    endtask

    initial begin
        int   seen;
        exp_t r;
        logic [WIDTH-1:0] ra, rb;
        logic rc, rs;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
`ifdef CHUNKED_ADDER_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

        send(16'd5, 16'd3, 1'b0, 1'b0, 17'h00008, 1'b0, 1'b1);
        collect("add_5_3");
        @(negedge clk);
        chk("add_5_3_pulse", 32'(bus.out_valid), 32'd0);
        chk("add_5_3_idle", 32'(bus.in_ready), 32'd1);

        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0, 1'b1);
        collect("add_max");
        @(negedge clk);

        send(16'd4, 16'd5, 1'b1, 1'b1, 17'h0FFFF, 1'b0, 1'b1);
        collect("sub_4_5");
        @(negedge clk);

        send(16'h8000, 16'd1, 1'b0, 1'b1, 17'h17FFF, 1'b1, 1'b1);
        collect("sub_ovf");
        @(negedge clk);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b1);
        collect("add_ovf");
        @(negedge clk);

        // Back-pressure: result must hold and new operands must be ignored
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0, 1'b1);
        collect("hold");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'hAAAA;
            bus.b        = 16'h5555;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_sum", 32'(bus.sum), 32'h05556);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("ignored_in_valid_no_result", 32'(seen), 32'd0);

        // Reset wins over a simultaneous accept
        bus.a        = 16'd1;
        bus.b        = 16'd1;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_prio_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rst_prio_no_result", 32'(seen), 32'd0);

        // Reset mid-transaction aborts it
        send(16'h00F0, 16'h000F, 1'b0, 1'b0, 17'h000FF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        send(16'd4, 16'd5, 1'b1, 1'b0, 17'h0000A, 1'b0, 1'b1);
        collect("after_abort");
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            r  = model(ra, rb, rc, rs);
            send(ra, rb, rc, rs, r.sum, r.ovf, 1'b1);
            collect("random");
            @(negedge clk);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits, at least 4.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH is an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: unsigned operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, used only when sub is 0.
REQ-009 SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH+1 bits: the result, with the MSB as carry-out (add) or not-borrow (sub).

Function
REQ-013 SHALL use a state machine with states IDLE, ADD and DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL accept operands when in_valid and in_ready are both high at a clock edge, then latch a, b, cin and sub and go to ADD.
REQ-016 SHALL, in ADD, add one CHUNK-bit slice per cycle, least-significant slice first, with a registered carry between slices.
REQ-017 SHALL use initial carry cin when sub=0; when sub=1 it SHALL add ~b with initial carry 1 and ignore cin.
REQ-018 SHALL, after the N-th slice, write the final carry to sum[WIDTH] and go to DONE.
REQ-019 SHALL assert out_valid in DONE, N+1 cycles after the accept edge.
REQ-020 SHALL hold out_valid and sum stable until out_ready is high at an edge, then go to IDLE.
REQ-021 SHALL accept a new operand set no earlier than the cycle after leaving DONE, so each transaction occupies N+2 cycles.
REQ-022 SHALL ignore in_valid, a, b, cin and sub while in ADD or DONE.
REQ-023 SHALL, if out_ready is already high on DONE entry, hold out_valid for exactly one cycle.
REQ-024 SHALL wrap modulo 2^(WIDTH+1) with no saturation; 0xFFFF+0xFFFF+1 gives 0x1FFFF.

Reset
REQ-025 SHALL, with rst high at an edge, enter IDLE with out_valid=0, sum=0, internal carry=0 and in_ready=1 from the next cycle.
REQ-026 SHALL, if reset arrives in ADD or DONE, abort the transaction, discard the result and produce no out_valid pulse.
REQ-027 SHALL give rst priority over a simultaneous in_valid/in_ready accept or out_ready handshake.

Configuration
REQ-028 SHALL, when CHUNKED_ADDER_OVF_EN is defined, add output port ovf (1 bit) that is valid with out_valid: signed two's-complement overflow of the WIDTH-bit result, for add or subtract as selected.
REQ-029 SHALL reset ovf to 0 and hold it stable with sum.
REQ-030 SHALL, when CHUNKED_ADDER_OVF_EN is undefined, omit the ovf port and its logic with all other behaviour unchanged.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-031 SHALL test: a=5, b=3, cin=0, sub=0, out_ready=1 -> out_valid 5 cycles after accept, sum=0x00008, one-cycle pulse.
REQ-032 SHALL test: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0x1FFFF; with OVF_EN, ovf=0.
REQ-033 SHALL test: sub=1, a=4, b=5, cin=1 -> sum=0x0FFFF (borrow, MSB 0); with OVF_EN, ovf=0; then a=0x8000, b=1 -> sum=0x17FFF, ovf=1.
REQ-034 SHALL test: out_ready held low for 10 cycles -> out_valid and sum stable, in_ready low, new in_valid ignored; release -> IDLE the next cycle.
REQ-035 SHALL test: rst pulsed 2 cycles after accept -> no out_valid, sum=0, in_ready=1; the next transaction (a=4, b=5, cin=1) gives sum=0x0000A.
